// File: rtl/tt_arith_pkg.sv
// Shared definitions for the Tiny Tapeout arithmetic slot: the serial
// subtractor and its parallel adder companion.
//   state_e        : 2-bit control state encoding {IDLE, RUN, DONE}
//   TT_ARITH_W_DEF : default operand width
//   tt_cnt_w()     : bit-counter width for a W-bit serial datapath
package tt_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int TT_ARITH_W_DEF = 8;

  // Counter must index bits 0..W-1; never narrower than one bit.
  function automatic int tt_cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/tt_serial_sub_if.sv
// Operand/result handshake bundle for tt_serial_sub.
//   in_valid/in_ready/a/b          : operand channel (producer -> block)
//   out_valid/out_ready/diff/borrow: result channel (block -> consumer)
//   ovf                            : signed overflow, only with TT_SUB_OVF_EN
// master = producer/consumer side, slave = the subtractor.
interface tt_serial_sub_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef TT_SUB_OVF_EN
  logic         ovf;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, diff, borrow, ovf);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, diff, borrow, ovf);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, diff, borrow);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, diff, borrow);
`endif
endinterface

// File: rtl/tt_serial_sub_fsub_cell.sv
// tt_fsub_cell: combinational 1-bit full subtractor, d = a - b - bin.
//   a_i, b_i, bin_i : operand bits and incoming borrow
//   d_o, bout_o     : difference bit and outgoing borrow
// Built from two half-subtractors; outgoing borrow is the OR of theirs.
module tt_fsub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  logic hs1_d, hs1_b, hs2_b;

  // a - b
  assign hs1_d = a_i ^ b_i;
  assign hs1_b = ~a_i & b_i;
  // (a - b) - bin
  assign d_o   = hs1_d ^ bin_i;
  assign hs2_b = ~hs1_d & bin_i;

  assign bout_o = hs1_b | hs2_b;
endmodule

// File: rtl/tt_serial_sub.sv
// tt_serial_sub: bit-serial W-bit subtractor, diff = a - b, LSB first.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : tt_serial_sub_if.slave (operand and result handshakes)
// One operand pair is accepted in IDLE, W RUN cycles each resolve one bit,
// and the result is presented in DONE until the consumer takes it.
// Optional feature macro: TT_SUB_OVF_EN adds the signed overflow flag.
module tt_serial_sub
  import tt_arith_pkg::*;
#(
  parameter int W = TT_ARITH_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  tt_serial_sub_if.slave  bus
);

  localparam int CW = tt_cnt_w(W);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  a_q,     a_d;
  logic [W-1:0]  b_q,     b_d;
  logic [W-1:0]  diff_q,  diff_d;
  logic          bin_q,   bin_d;
  logic          d_bit,   bout_bit;

  // The single subtractor cell always looks at the current LSBs.
  tt_fsub_cell u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (bin_q),
    .d_o    (d_bit),
    .bout_o (bout_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bin_d   = bin_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          bin_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // Result bits enter at the MSB so bit 0 lands at diff[0] after W shifts.
        diff_d = {d_bit, diff_q[W-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bin_d  = bout_bit;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bin_q   <= bin_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.diff      = diff_q;
  // The running borrow after the MSB is the final borrow.
  assign bus.borrow    = bin_q;

`ifdef TT_SUB_OVF_EN
  // Operand MSBs are shifted away during RUN, so keep copies for the flag.
  logic a_msb_q, b_msb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.in_valid) begin
      a_msb_q <= bus.a[W-1];
      b_msb_q <= bus.b[W-1];
    end
  end

  // Signed overflow: operand signs differ and the result sign differs from a.
  assign bus.ovf = (state_q == ST_DONE) && (a_msb_q != b_msb_q) &&
                   (diff_q[W-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_tt_serial_sub.sv
// Self-checking bench for tt_serial_sub (W=8): directed operand cases,
// back-pressure hold, mid-run reset, back-to-back streaming and a
// randomized handshake sweep against an arithmetic reference model.
module tb_tt_serial_sub;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tt_serial_sub_if #(.W(W)) bus ();

  tt_serial_sub #(.W(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    int r;
    r = (int'(a) - int'(b)) % (1 << W);
    if (r < 0) r = r + (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
    return int'(a) < int'(b);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, r;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    r  = sa - sb;
    return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    chk({tag, "_diff"},   32'(bus.diff),   32'(ref_diff(a, b)));
    chk({tag, "_borrow"}, 32'(bus.borrow), 32'(ref_borrow(a, b)));
`ifdef TT_SUB_OVF_EN
    chk({tag, "_ovf"},    32'(bus.ovf),    32'(ref_ovf(a, b)));
`endif
  endtask

  // One operation: checks latency, result, optional back-pressure hold
  // (with ignored in_valid), and return to IDLE with result retained.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    int n;
    bus.a = a;
    bus.b = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    tick();                       // handshake edge: cycle 0 ends
    bus.in_valid = 1'b0;
    bus.a = ~a;                   // operand changes after accept must not matter
    bus.b = W'($urandom);
    n = 1;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(W + 1));
    chk_result(tag, a, b);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;        // ignored outside IDLE
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      tick();
      chk({tag, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(bus.in_ready),  32'd0);
      chk_result({tag, "_hold"}, a, b);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_idle_vld"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(bus.in_ready),  32'd1);
    chk({tag, "_idle_diff"}, 32'(bus.diff), 32'(ref_diff(a, b)));
    bus.out_ready = 1'b0;
  endtask

  // Streaming: random operands every cycle, results matched in order via a queue.
  task automatic stream(input string tag, input int nres, input bit rand_hs, input bit chk_period);
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int done, cyc, last;
    done = 0; cyc = 0; last = -1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    while (done < nres && cyc < 3000) begin
      if (bus.out_valid && bus.out_ready) begin
        chk({tag, "_qnonempty"}, 32'(qa.size() > 0), 32'd1);
        if (qa.size() > 0) begin
          chk_result(tag, qa[0], qb[0]);
          void'(qa.pop_front());
          void'(qb.pop_front());
        end
        if (chk_period && last >= 0) chk({tag, "_period"}, 32'(cyc - last), 32'(W + 2));
        last = cyc;
        done++;
      end
      if (bus.in_valid && bus.in_ready) begin
        qa.push_back(bus.a);
        qb.push_back(bus.b);
      end
      tick();
      cyc++;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      if (rand_hs) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end
    end
    chk({tag, "_count"}, 32'(done), 32'(nres));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    do_reset();
    chk("rst_rdy",    32'(bus.in_ready),  32'd1);
    chk("rst_vld",    32'(bus.out_valid), 32'd0);
    chk("rst_diff",   32'(bus.diff),      32'd0);
    chk("rst_borrow", 32'(bus.borrow),    32'd0);
`ifdef TT_SUB_OVF_EN
    chk("rst_ovf",    32'(bus.ovf),       32'd0);
`endif

    // Directed operand cases
    run_op("t1",     8'h2A, 8'h0F, 0);
    run_op("t2a",    8'h05, 8'h07, 0);
    run_op("t2b",    8'h33, 8'h33, 0);
    run_op("b0",     8'hC5, 8'h00, 0);
    run_op("a0b1",   8'h00, 8'h01, 0);
    run_op("t3a",    8'h80, 8'h01, 0);
    run_op("t3b",    8'h10, 8'h01, 0);
    run_op("ovfneg", 8'h7F, 8'hFF, 0);

    // Back-pressure: result held 5 cycles in DONE
    run_op("t4", 8'h9C, 8'hD3, 5);

    // Reset during RUN bit 3 discards partial result
    bus.a = 8'hFF;
    bus.b = 8'h00;
    bus.in_valid = 1'b1;
    tick();                       // accepted; RUN, bit 0 next
    bus.in_valid = 1'b0;
    tick(); tick(); tick();       // bits 0..2 done, bit 3 in progress
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rdy",    32'(bus.in_ready),  32'd1);
    chk("t5_vld",    32'(bus.out_valid), 32'd0);
    chk("t5_diff",   32'(bus.diff),      32'd0);
    chk("t5_borrow", 32'(bus.borrow),    32'd0);
    run_op("t5_after", 8'h41, 8'h62, 0);

    // Back-to-back results at full rate
    do_reset();
    stream("t6", 4, 1'b0, 1'b1);

    // Randomized handshake sweep
    do_reset();
    stream("sweep", 24, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
